// File: rtl/mem_copy_engine_if.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_if
//
// Purpose: bundles the command side and the data-memory side of the
// mem_copy_engine into one connection.
//
// Signals:
//   start, mode, src, dst, len, pattern : command, sampled by the engine in IDLE
//   busy, done, count                   : command status back to the issuer
//   mem_a, mem_we, mem_wd               : data-memory port driven by the engine
//   mem_rd                              : data-memory read data into the engine
//   dbg_state                           : engine FSM state (IDLE=0, READ=1,
//                                         WRITE=2, DONE=3) for observation only
//
// Handshake: 'start' is a single-cycle strobe that is only accepted while the
// engine is idle (busy=0, done=0).  The command fields are captured on that
// same edge and may change freely afterwards.  'busy' stays high for every
// cycle that touches memory; 'done' pulses for exactly one cycle after the
// last write, and the first cycle after that pulse can accept a new 'start'.
//
// Modports:
//   master : the engine itself
//   slave  : the command issuer / memory model side
// -----------------------------------------------------------------------------
interface mem_copy_engine_if #(
    parameter int LEN_W = 12
);
    logic             start;
    logic             mode;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;

    logic [31:0]      mem_rd;
    logic [31:0]      mem_a;
    logic             mem_we;
    logic [31:0]      mem_wd;

    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;

    logic [1:0]       dbg_state;

    modport master (
        input  start, mode, src, dst, len, pattern, mem_rd,
        output mem_a, mem_we, mem_wd, busy, done, count, dbg_state
    );

    modport slave (
        output start, mode, src, dst, len, pattern, mem_rd,
        input  mem_a, mem_we, mem_wd, busy, done, count, dbg_state
    );
endinterface

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Purpose: moves (copy) or fills (constant fill) blocks of 32-bit words in the
// data memory through its single port, in ascending address order, without
// processor involvement.  The engine owns the memory port while busy.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous, active-high; forces IDLE and zeroes all outputs
//   bus    : mem_copy_engine_if.master
//            in : start, mode (0=copy, 1=fill), src, dst, len, pattern, mem_rd
//            out: mem_a, mem_we, mem_wd, busy, done, count, dbg_state
//
// Timing summary:
//   copy : READ/WRITE pair per word (2 cycles/word)
//   fill : one WRITE per word (1 cycle/word)
//   len=0: straight to DONE, no memory access
// Every output is a flop; the next-cycle output values are decided in the same
// block that decides the next state, so nothing combinational from 'start' or
// 'mem_rd' reaches an output.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int LEN_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    mem_copy_engine_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             mode_r;   // latched command mode
    logic [31:0]      src_p;    // current source pointer (byte address)
    logic [31:0]      dst_p;    // current destination pointer (byte address)
    logic [LEN_W-1:0] rem;      // words still to write
    logic [31:0]      pat_r;    // latched fill value

    logic [31:0]      src_nxt;
    logic [31:0]      dst_nxt;

    // Pointers advance by one word; wrap-around past 2^32 is intentional.
    assign src_nxt = src_p + 32'd4;
    assign dst_nxt = dst_p + 32'd4;

    assign bus.dbg_state = state;

    // The memory port is word addressed: low two bits never leave the engine.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // mem_wd doubles as the copy data register: in READ the read data is
    // captured straight into it, so it is already presented during WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_r     <= 1'b0;
            src_p      <= 32'd0;
            dst_p      <= 32'd0;
            rem        <= '0;
            pat_r      <= 32'd0;
            bus.mem_a  <= 32'd0;
            bus.mem_we <= 1'b0;
            bus.mem_wd <= 32'd0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.mem_a  <= 32'd0;
                    bus.mem_we <= 1'b0;
                    bus.mem_wd <= 32'd0;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b0;
                    if (bus.start) begin
                        mode_r    <= bus.mode;
                        src_p     <= bus.src;
                        dst_p     <= bus.dst;
                        rem       <= bus.len;
                        pat_r     <= bus.pattern;
                        bus.count <= '0;
                        if (bus.len == '0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else if (!bus.mode) begin
                            state     <= S_READ;
                            bus.mem_a <= word_addr(bus.src);
                            bus.busy  <= 1'b1;
                        end else begin
                            state      <= S_WRITE;
                            bus.mem_a  <= word_addr(bus.dst);
                            bus.mem_we <= 1'b1;
                            bus.mem_wd <= bus.pattern;
                            bus.busy   <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    state      <= S_WRITE;
                    bus.mem_a  <= word_addr(dst_p);
                    bus.mem_we <= 1'b1;
                    bus.mem_wd <= bus.mem_rd;
                    bus.busy   <= 1'b1;
                    bus.done   <= 1'b0;
                end

                S_WRITE: begin
                    // The memory commits mem_wd on this edge.
                    bus.count <= bus.count + LEN_ONE;
                    src_p     <= src_nxt;
                    dst_p     <= dst_nxt;
                    rem       <= rem - LEN_ONE;
                    if (rem == LEN_ONE) begin
                        state      <= S_DONE;
                        bus.mem_a  <= 32'd0;
                        bus.mem_we <= 1'b0;
                        bus.mem_wd <= 32'd0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end else if (!mode_r) begin
                        state      <= S_READ;
                        bus.mem_a  <= word_addr(src_nxt);
                        bus.mem_we <= 1'b0;
                        bus.mem_wd <= 32'd0;
                        bus.busy   <= 1'b1;
                        bus.done   <= 1'b0;
                    end else begin
                        state      <= S_WRITE;
                        bus.mem_a  <= word_addr(dst_nxt);
                        bus.mem_we <= 1'b1;
                        bus.mem_wd <= pat_r;
                        bus.busy   <= 1'b1;
                        bus.done   <= 1'b0;
                    end
                end

                S_DONE: begin
                    // 'start' is not looked at here; count keeps its final value.
                    state      <= S_IDLE;
                    bus.mem_a  <= 32'd0;
                    bus.mem_we <= 1'b0;
                    bus.mem_wd <= 32'd0;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    bus.mem_a  <= 32'd0;
                    bus.mem_we <= 1'b0;
                    bus.mem_wd <= 32'd0;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Bench for mem_copy_engine: a sparse data-memory model attached to the
// engine's port, a reference memory plus per-cycle expected outputs computed
// from the word-by-word copy/fill rules, directed scenarios and random commands.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_copy_engine;
    localparam int LEN_W = 12;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.LEN_W(LEN_W)) bus();

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      a;
        logic             we;
        logic [31:0]      wd;
        logic             wd_care;
        logic             busy;
        logic             done;
        logic [LEN_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [31:0]      dut_mem [logic [31:0]];   // memory the engine really writes
    logic [31:0]      ref_mem [logic [31:0]];   // reference memory
    logic [LEN_W-1:0] last_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] rd_dut(input logic [31:0] a);
        if (dut_mem.exists(a)) return dut_mem[a];
        return 32'h0;
    endfunction

    // ---------------- data memory attached to the engine ----------------
    // Write commits on the edge that ends a write cycle; read data is settled
    // well before the edge that samples it.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) dut_mem[bus.mem_a] = bus.mem_wd;
    end

    always @(negedge clk) begin
        bus.mem_rd = rd_dut(bus.mem_a);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        exp_t e;
        if (reset) begin
            chk("rst_mem_a",  bus.mem_a, 32'h0);
            chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
            chk("rst_mem_wd", bus.mem_wd, 32'h0);
            chk("rst_busy",   32'(bus.busy), 32'h0);
            chk("rst_done",   32'(bus.done), 32'h0);
            chk("rst_count",  32'(bus.count), 32'h0);
            last_cnt = '0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_a",  bus.mem_a, e.a);
            chk("mem_we", 32'(bus.mem_we), 32'(e.we));
            if (e.wd_care) chk("mem_wd", bus.mem_wd, e.wd);
            chk("busy",   32'(bus.busy), 32'(e.busy));
            chk("done",   32'(bus.done), 32'(e.done));
            chk("count",  32'(bus.count), 32'(e.cnt));
            if (e.we) ref_mem[e.a] = e.wd;
            last_cnt = e.cnt;
        end else begin
            chk("idle_mem_a",  bus.mem_a, 32'h0);
            chk("idle_mem_we", 32'(bus.mem_we), 32'h0);
            chk("idle_mem_wd", bus.mem_wd, 32'h0);
            chk("idle_busy",   32'(bus.busy), 32'h0);
            chk("idle_done",   32'(bus.done), 32'h0);
            chk("idle_count",  32'(bus.count), 32'(last_cnt));
        end
    end

    // ---------------- reference model ----------------
    function automatic exp_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input logic wd_care, input logic busy, input logic done,
                                input logic [LEN_W-1:0] cnt);
        exp_t e;
        e.a = a; e.we = we; e.wd = wd; e.wd_care = wd_care;
        e.busy = busy; e.done = done; e.cnt = cnt;
        return e;
    endfunction

    // Expand one command into the sequence of port cycles it must produce:
    // words are processed one at a time in ascending order, so a copy into an
    // overlapping region reads values already written by this command.
    task automatic push_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [LEN_W-1:0] n, input logic [31:0] p);
        logic [31:0] scratch [logic [31:0]];
        logic [31:0] sa, da, v;
        scratch = ref_mem;
        for (int i = 0; i < int'(n); i++) begin
            sa = (s + 32'(i) * 32'd4) & 32'hFFFF_FFFC;
            da = (d + 32'(i) * 32'd4) & 32'hFFFF_FFFC;
            if (!m) begin
                v = scratch.exists(sa) ? scratch[sa] : 32'h0;
                exp_q.push_back(mk(sa, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, LEN_W'(i)));
            end else begin
                v = p;
            end
            exp_q.push_back(mk(da, 1'b1, v, 1'b1, 1'b1, 1'b0, LEN_W'(i)));
            scratch[da] = v;
        end
        exp_q.push_back(mk(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, n));
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] n, input logic [31:0] p);
        @(negedge clk);
        #1;
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.src     = s;
        bus.dst     = d;
        bus.len     = n;
        bus.pattern = p;
        @(posedge clk);
        #1;
        push_cmd(m, s, d, n, p);
        bus.start = 1'b0;
    endtask

    int               lat;
    int               busy_cyc;
    int               we_cyc;
    logic [31:0]      obs_a[$];
    logic [LEN_W-1:0] done_cnt;

    // lat = number of edges after the start edge before the done cycle.
    task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [LEN_W-1:0] n, input logic [31:0] p, input bit inject);
        bit seen;
        issue(m, s, d, n, p);
        lat = -1; busy_cyc = 0; we_cyc = 0; obs_a.delete(); seen = 1'b0; done_cnt = '0;
        for (int k = 0; k < 2 * int'(n) + 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.busy)   busy_cyc++;
            if (bus.mem_we) we_cyc++;
            if (bus.busy)   obs_a.push_back(bus.mem_a);
            if (bus.done) begin
                seen = 1'b1; lat = k; done_cnt = bus.count;
            end
            if (inject && k == 0) begin
                #1; bus.start = 1'b1; bus.mode = 1'b0; bus.dst = 32'h300;
            end
            if (inject && k == 1) begin
                #1; bus.start = 1'b0;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * int'(n) + 8);
        end
    endtask

    task automatic mem_compare();
        chk("mem_size", 32'(dut_mem.size()), 32'(ref_mem.size()));
        foreach (ref_mem[addr]) begin
            chk("mem_word", dut_mem.exists(addr) ? dut_mem[addr] : 32'hx, ref_mem[addr]);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        dut_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic        m;
        logic [31:0] s, d, p;
        logic [LEN_W-1:0] n;
        int          extra_done;

        bus.start = 1'b0; bus.mode = 1'b0; bus.src = 32'h0; bus.dst = 32'h0;
        bus.len = '0; bus.pattern = 32'h0; bus.mem_rd = 32'h0;

        for (int i = 0; i < 256; i++) poke(32'(i) * 32'd4, $urandom);
        poke(32'h100, 32'h11); poke(32'h104, 32'h22); poke(32'h108, 32'h33);
        poke(32'h50, 32'h5555_5555);
        poke(32'h300, 32'hA5A5_A5A5);
        poke(32'h384, 32'h7777_7777);

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_a", bus.mem_a, 32'h0);
        chk("reset_count", 32'(bus.count), 32'h0);
        chk("reset_busy",  32'(bus.busy), 32'h0);
        chk("reset_state", 32'(bus.dbg_state), 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        // copy 3 words 0x100 -> 0x200
        run_cmd(1'b0, 32'h100, 32'h200, 12'd3, 32'h0, 1'b0);
        chk("copy_latency", 32'(lat), 32'd6);
        chk("copy_busy_cycles", 32'(busy_cyc), 32'd6);
        chk("copy_count", 32'(done_cnt), 32'd3);
        chk("copy_w0", rd_dut(32'h200), 32'h11);
        chk("copy_w1", rd_dut(32'h204), 32'h22);
        chk("copy_w2", rd_dut(32'h208), 32'h33);
        mem_compare();

        // fill 4 words at 0x40
        run_cmd(1'b1, 32'h0, 32'h40, 12'd4, 32'hDEAD_BEEF, 1'b0);
        chk("fill_latency", 32'(lat), 32'd4);
        chk("fill_w0", rd_dut(32'h40), 32'hDEAD_BEEF);
        chk("fill_w3", rd_dut(32'h4C), 32'hDEAD_BEEF);
        chk("fill_untouched", rd_dut(32'h50), 32'h5555_5555);
        chk("fill_count", 32'(done_cnt), 32'd4);
        mem_compare();

        // len = 0
        run_cmd(1'b0, 32'h100, 32'h200, 12'd0, 32'h0, 1'b0);
        chk("len0_latency", 32'(lat), 32'd0);
        chk("len0_writes", 32'(we_cyc), 32'd0);
        chk("len0_busy", 32'(busy_cyc), 32'd0);

        // misaligned addresses
        run_cmd(1'b0, 32'h103, 32'h207, 12'd1, 32'h0, 1'b0);
        chk("misal_rd_addr", obs_a.size() > 0 ? obs_a[0] : 32'hx, 32'h100);
        chk("misal_wr_addr", obs_a.size() > 1 ? obs_a[1] : 32'hx, 32'h204);
        chk("misal_data", rd_dut(32'h204), 32'h11);
        mem_compare();

        // start while busy is ignored
        run_cmd(1'b1, 32'h0, 32'h80, 12'd2, 32'hCAFE_F00D, 1'b1);
        extra_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        chk("busy_start_done_once", 32'(extra_done), 32'd0);
        chk("busy_start_dst_kept", rd_dut(32'h84), 32'hCAFE_F00D);
        chk("busy_start_no_300", rd_dut(32'h300), 32'hA5A5_A5A5);
        mem_compare();

        // reset during the write of word 2 of a 4-word copy
        issue(1'b0, 32'h100, 32'h380, 12'd4, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.mem_we), 32'h0);
        chk("midrst_a", bus.mem_a, 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_count", 32'(bus.count), 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        chk("midrst_w1", rd_dut(32'h380), 32'h11);
        chk("midrst_w2", rd_dut(32'h384), 32'h7777_7777);
        mem_compare();
        run_cmd(1'b0, 32'h100, 32'h380, 12'd4, 32'h0, 1'b0);
        chk("after_rst_latency", 32'(lat), 32'd8);
        chk("after_rst_count", 32'(done_cnt), 32'd4);
        mem_compare();

        // address wrap on fill
        run_cmd(1'b1, 32'h0, 32'hFFFF_FFFC, 12'd2, 32'h1234_5678, 1'b0);
        chk("wrap_a0", obs_a.size() > 0 ? obs_a[0] : 32'hx, 32'hFFFF_FFFC);
        chk("wrap_a1", obs_a.size() > 1 ? obs_a[1] : 32'hx, 32'h0000_0000);
        chk("wrap_count", 32'(done_cnt), 32'd2);
        chk("wrap_w0", rd_dut(32'h0), 32'h1234_5678);
        mem_compare();

        // overlapping copy propagates the first word upward
        run_cmd(1'b0, 32'h100, 32'h104, 12'd3, 32'h0, 1'b0);
        chk("overlap_w2", rd_dut(32'h10C), 32'h11);
        mem_compare();

        // random commands
        repeat (25) begin
            m = 1'($urandom_range(0, 1));
            s = 32'($urandom_range(0, 32'h3E0));
            d = 32'($urandom_range(0, 32'h3E0));
            n = LEN_W'($urandom_range(0, 8));
            p = $urandom;
            run_cmd(m, s, d, n, p, 1'b0);
            chk("rand_latency", 32'(lat), (n == '0) ? 32'd0 : (m ? 32'(n) : 32'(n) * 32'd2));
            chk("rand_count", 32'(done_cnt), 32'(n));
            mem_compare();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Memory-side initiator that drives the data memory's single port (`a`, `we`, `wd`, `rd`) to move or fill blocks of 32-bit words without processor involvement. It sits between the control logic that issues a start command and the data memory, owning the port while busy. It supports word copy (read-then-write per word) and constant fill (write-only), in ascending address order.

## Interface
- `LEN_W`, 12, width of the word-count input and `count` output (max 4095 words per command)
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE and the reset values listed below
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  1  0 = copy, 1 = fill; latched with `start`
- `src`  in  32  source byte address (copy); latched with `start`
- `dst`  in  32  destination byte address; latched with `start`
- `len`  in  LEN_W  number of words; latched with `start`
- `pattern`  in  32  fill value (fill); latched with `start`
- `mem_rd`  in  32  data-memory read data (combinational from `mem_a`)
- `mem_a`  out  32  data-memory byte address
- `mem_we`  out  1  data-memory write enable
- `mem_wd`  out  32  data-memory write data
- `busy`  out  1  high in READ and WRITE
- `done`  out  1  one-cycle completion pulse
- `count`  out  LEN_W  words written in current/last command

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches `mode`, `src`, `dst`, `len`, `pattern`; clears `count`. `len`=0 → DONE. Else copy → READ, fill → WRITE.
- READ (copy only): `mem_a` = current src pointer, `mem_we`=0; at clock edge capture `mem_rd` into data register, → WRITE.
- WRITE: `mem_a` = current dst pointer, `mem_we`=1, `mem_wd` = data register (copy) or latched pattern (fill). At edge: `count`+1, both pointers +4, remaining −1. Remaining reaches 0 → DONE; else copy → READ, fill → WRITE.
- DONE: `done`=1, `mem_we`=0, → IDLE unconditionally. `count` holds final value until next accepted `start`.
- Address low two bits are forced to 00 on `mem_a` (word aligned); pointers add 4 modulo 2^32 (wrap-around permitted, no error).
- Overlapping copy proceeds strictly ascending; dst inside (src, src+4·len) yields propagated data by design, not an error.
- `start` outside IDLE (including DONE) is ignored; latched command unaffected.
- In IDLE and DONE: `mem_a`=0, `mem_wd`=0, `mem_we`=0.

## Timing
- Reset values: state IDLE, `mem_a`=0, `mem_we`=0, `mem_wd`=0, `busy`=0, `done`=0, `count`=0, internal pointers/registers 0.
- Reset asserted mid-command: `mem_we` drops immediately (async), no further memory write; words already written stay written.
- All outputs are driven from registered state (no combinational path from `start` or `mem_rd` to outputs).
- Copy: 2 cycles/word. With `start` sampled at edge E0, first READ cycle follows E0; `done` is high for the single cycle after edge E0+2N.
- Fill: 1 cycle/word; `done` high in cycle after edge E0+N.
- `len`=0: `done` high in the cycle immediately after E0; no memory access.
- Earliest next accepted `start`: edge ending the DONE cycle +1 (i.e. first IDLE cycle).
- Memory write timing: data memory commits `mem_wd` on the edge that ends each WRITE cycle.

## Test plan
- Copy: preload words 0x11,0x22,0x33 at 0x100; start mode=0, src=0x100, dst=0x200, len=3 → memory 0x200..0x208 = 0x11,0x22,0x33; `done` exactly 6 cycles after start edge; `count`=3; `busy` high 6 cycles.
- Fill: mode=1, dst=0x40, len=4, pattern=0xDEADBEEF → words 0x40..0x4C = 0xDEADBEEF, `done` 4 cycles after start, 0x50 untouched.
- len=0 and misaligned: len=0 → `done` next cycle, no `mem_we`; then copy src=0x103, dst=0x207, len=1 → `mem_a` shows 0x100 then 0x204.
- Start while busy: second `start` with dst=0x300 during a len=2 fill → ignored; only original dst region written, single `done`.
- Reset mid-copy: assert `reset` during WRITE of word 2 of len=4 → `mem_we` low same cycle, outputs at reset values, only word 1 written; fresh command after release completes normally.
- Overlap/wrap: fill dst=0xFFFFFFFC, len=2 → `mem_a` = 0xFFFFFFFC then 0x00000000, `count`=2.
